// File: rtl/disp_mux_7seg_if.sv
// disp_mux_7seg_if: BCD register inputs and 7-segment drive outputs of the display multiplexer.
interface disp_mux_7seg_if;
    logic [7:0] hora, min, seg, dia, mes, year, horacrono, mincrono, segcrono;
    logic       AmPm, format;
    logic [1:0] page;
    logic [5:0] anodo;
    logic [6:0] segm;
    logic       dp, frame_tick;
    modport master (
        output hora, min, seg, dia, mes, year, horacrono, mincrono, segcrono, AmPm, format, page,
        input  anodo, segm, dp, frame_tick
    );
    modport slave (
        input  hora, min, seg, dia, mes, year, horacrono, mincrono, segcrono, AmPm, format, page,
        output anodo, segm, dp, frame_tick
    );
endinterface

// File: rtl/disp_mux_7seg.sv
// disp_mux_7seg: 6-digit common-anode multiplexer over per-frame BCD snapshots.
// Define AMPM_DP_EN to drive the rightmost decimal point as a PM indicator in 12 h time mode.
module disp_mux_7seg #(
    parameter int REFRESH_DIV = 50000
) (
    input logic            clock,
    input logic            reset,
    disp_mux_7seg_if.slave bus
);
    localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic          r_run;
    logic [7:0]    r_snap [9];
    logic [1:0]    r_page_s;
    logic          r_tick;
    logic [5:0]    r_anodo;
    logic [6:0]    r_segm;
    logic          r_dp;
`ifdef AMPM_DP_EN
    logic          r_ampm_s, r_format_s;
`endif

    logic       w_term, w_snap, w_blank, w_dp;
    logic [3:0] w_fi, w_tens, w_nib;
    logic [7:0] w_byte;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b0111111;
        endcase
    endfunction

    // The first cycle after reset release also snapshots, so a frame never shows stale zeros for long.
    assign w_term  = r_presc == PW'(REFRESH_DIV - 1);
    assign w_snap  = !r_run || (w_term && r_idx == 3'd5);
    assign w_blank = r_page_s == 2'd3;
    assign w_fi    = 4'(r_page_s) * 4'd3 + {2'b00, r_idx[2:1]};
    assign w_byte  = w_fi < 4'd9 ? r_snap[w_fi] : 8'h00;
    assign w_tens  = {w_byte[7] & (w_fi != 4'd0), w_byte[6:4]};
    assign w_nib   = r_idx[0] ? w_byte[3:0] : w_tens;
`ifdef AMPM_DP_EN
    assign w_dp    = !(r_page_s == 2'd0 && r_format_s && r_ampm_s && r_idx == 3'd5);
`else
    assign w_dp    = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_idx    <= 3'd0;
            r_run    <= 1'b0;
            for (int i = 0; i < 9; i++) r_snap[i] <= 8'h00;
            r_page_s <= 2'd0;
            r_tick   <= 1'b0;
            r_anodo  <= 6'h3F;
            r_segm   <= 7'h7F;
            r_dp     <= 1'b1;
`ifdef AMPM_DP_EN
            r_ampm_s   <= 1'b0;
            r_format_s <= 1'b0;
`endif
        end else begin
            r_presc <= w_term ? '0 : r_presc + PW'(1);
            if (w_term) r_idx <= r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1;
            r_run  <= 1'b1;
            r_tick <= w_snap;
            if (w_snap) begin
                r_snap[0] <= bus.hora;
                r_snap[1] <= bus.min;
                r_snap[2] <= bus.seg;
                r_snap[3] <= bus.dia;
                r_snap[4] <= bus.mes;
                r_snap[5] <= bus.year;
                r_snap[6] <= bus.horacrono;
                r_snap[7] <= bus.mincrono;
                r_snap[8] <= bus.segcrono;
                r_page_s  <= bus.page;
`ifdef AMPM_DP_EN
                r_ampm_s   <= bus.AmPm;
                r_format_s <= bus.format;
`endif
            end
            r_anodo <= w_blank ? 6'h3F : ~(6'b100000 >> r_idx);
            r_segm  <= w_blank ? 7'h7F : dec7(w_nib);
            r_dp    <= w_dp;
        end
    end

    assign bus.anodo      = r_anodo;
    assign bus.segm       = r_segm;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_disp_mux_7seg.sv
// tb_disp_mux_7seg: directed checks of digit scan, snapshotting, blanking, reset and DIV=1 scan.
module tb_disp_mux_7seg;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    logic tick_ok;

    logic [5:0] exp_an [6] = '{6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};
    logic [6:0] exp_t  [6] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010};
    logic [6:0] exp_d  [6] = '{7'b1000000, 7'b0010000, 7'b0110000, 7'b0111111, 7'b0100100, 7'b0010010};

    always #5 clock = ~clock;

    disp_mux_7seg_if bus ();
    disp_mux_7seg_if bus1 ();

    disp_mux_7seg #(.REFRESH_DIV(4)) u_dut (.clock(clock), .reset(reset), .bus(bus));
    disp_mux_7seg #(.REFRESH_DIV(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

    task automatic wait_tick(input int which, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            ok = (which == 0) ? bus.frame_tick : bus1.frame_tick;
        end
    endtask

    task automatic test_reset;
        {bus.dia, bus.mes, bus.year, bus.horacrono, bus.mincrono, bus.segcrono} = '0;
        bus.hora = 8'h12; bus.min = 8'h34; bus.seg = 8'h56;
        bus.AmPm = 1'b0; bus.format = 1'b0; bus.page = 2'd0;
        {bus1.dia, bus1.mes, bus1.year, bus1.horacrono, bus1.mincrono, bus1.segcrono} = '0;
        bus1.hora = 8'h12; bus1.min = 8'h34; bus1.seg = 8'h56;
        bus1.AmPm = 1'b0; bus1.format = 1'b0; bus1.page = 2'd0;
        repeat (2) @(negedge clock);
        n_run++; if (bus.anodo !== 6'h3F) begin n_fail++; $display("FAIL reset_anodo got %b want 111111", bus.anodo); end
        n_run++; if (bus.segm !== 7'h7F) begin n_fail++; $display("FAIL reset_segm got %b want 1111111", bus.segm); end
        n_run++; if (bus.dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", bus.dp); end
        n_run++; if (bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", bus.frame_tick); end
    endtask

    task automatic test_time;
        reset = 1'b1;
        wait_tick(0, tick_ok);
        n_run++; if (tick_ok !== 1'b1) begin n_fail++; $display("FAIL time_first_tick got timeout want tick"); end
        wait_tick(0, tick_ok);
        n_run++; if (tick_ok !== 1'b1) begin n_fail++; $display("FAIL time_second_tick got timeout want tick"); end
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            n_run++; if (bus.anodo !== exp_an[c/4]) begin n_fail++; $display("FAIL time_anodo c=%0d got %b want %b", c, bus.anodo, exp_an[c/4]); end
            n_run++; if (bus.segm !== exp_t[c/4]) begin n_fail++; $display("FAIL time_segm c=%0d got %b want %b", c, bus.segm, exp_t[c/4]); end
            n_run++; if (bus.frame_tick !== (c == 23)) begin n_fail++; $display("FAIL time_tick c=%0d got %b want %b", c, bus.frame_tick, c == 23); end
        end
    endtask

    task automatic test_date;
        bus.page = 2'd1; bus.dia = 8'h09; bus.mes = 8'h3A; bus.year = 8'h25;
        wait_tick(0, tick_ok);
        n_run++; if (tick_ok !== 1'b1) begin n_fail++; $display("FAIL date_tick got timeout want tick"); end
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            n_run++; if (bus.anodo !== exp_an[c/4]) begin n_fail++; $display("FAIL date_anodo c=%0d got %b want %b", c, bus.anodo, exp_an[c/4]); end
            n_run++; if (bus.segm !== exp_d[c/4]) begin n_fail++; $display("FAIL date_segm c=%0d got %b want %b", c, bus.segm, exp_d[c/4]); end
        end
    endtask

    task automatic test_update;
        bus.page = 2'd0; bus.hora = 8'h12; bus.min = 8'h34; bus.seg = 8'h56;
        wait_tick(0, tick_ok);
        n_run++; if (tick_ok !== 1'b1) begin n_fail++; $display("FAIL upd_tick got timeout want tick"); end
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            if (c == 9) bus.seg = 8'h57;
            if (c == 17) begin
                n_run++; if (bus.segm !== 7'b0010010) begin n_fail++; $display("FAIL upd_old_d4 got %b want 0010010", bus.segm); end
            end
            if (c == 21) begin
                n_run++; if (bus.segm !== 7'b0000010) begin n_fail++; $display("FAIL upd_old_d5 got %b want 0000010", bus.segm); end
            end
            if (c == 23) begin
                n_run++; if (bus.frame_tick !== 1'b1) begin n_fail++; $display("FAIL upd_tick_period got %b want 1", bus.frame_tick); end
            end
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            if (c == 21) begin
                n_run++; if (bus.segm !== 7'b1111000) begin n_fail++; $display("FAIL upd_new_d5 got %b want 1111000", bus.segm); end
            end
        end
    endtask

    task automatic test_blank;
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            if (c == 5) bus.page = 2'd3;
            if (c == 10) begin
                n_run++; if (bus.anodo !== 6'b110111) begin n_fail++; $display("FAIL blank_early_anodo got %b want 110111", bus.anodo); end
                n_run++; if (bus.segm !== 7'b0110000) begin n_fail++; $display("FAIL blank_early_segm got %b want 0110000", bus.segm); end
            end
        end
        n_run++; if (bus.frame_tick !== 1'b1) begin n_fail++; $display("FAIL blank_tick got %b want 1", bus.frame_tick); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            n_run++; if (bus.anodo !== 6'h3F) begin n_fail++; $display("FAIL blank_anodo c=%0d got %b want 111111", c, bus.anodo); end
            n_run++; if (bus.segm !== 7'h7F) begin n_fail++; $display("FAIL blank_segm c=%0d got %b want 1111111", c, bus.segm); end
            n_run++; if (bus.dp !== 1'b1) begin n_fail++; $display("FAIL blank_dp c=%0d got %b want 1", c, bus.dp); end
        end
    endtask

    task automatic test_reset_mid;
        bus.page = 2'd0;
        wait_tick(0, tick_ok);
        n_run++; if (tick_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_tick got timeout want tick"); end
        repeat (13) @(negedge clock);
        n_run++; if (bus.anodo !== 6'b111011) begin n_fail++; $display("FAIL rmid_pre_anodo got %b want 111011", bus.anodo); end
        reset = 1'b0;
        #1;
        n_run++; if (bus.anodo !== 6'h3F) begin n_fail++; $display("FAIL rmid_anodo got %b want 111111", bus.anodo); end
        n_run++; if (bus.segm !== 7'h7F) begin n_fail++; $display("FAIL rmid_segm got %b want 1111111", bus.segm); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_run++; if (bus.frame_tick !== 1'b1) begin n_fail++; $display("FAIL rmid_restart_tick got %b want 1", bus.frame_tick); end
        n_run++; if (bus.anodo !== 6'b011111) begin n_fail++; $display("FAIL rmid_restart_anodo got %b want 011111", bus.anodo); end
        n_run++; if (bus.segm !== 7'b1000000) begin n_fail++; $display("FAIL rmid_restart_segm got %b want 1000000", bus.segm); end
        @(negedge clock);
        n_run++; if (bus.segm !== 7'b1111001) begin n_fail++; $display("FAIL rmid_next_segm got %b want 1111001", bus.segm); end
        n_run++; if (bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL rmid_next_tick got %b want 0", bus.frame_tick); end
    endtask

    task automatic test_dp;
        logic want;
        bus.format = 1'b1; bus.AmPm = 1'b1;
        wait_tick(0, tick_ok);
        n_run++; if (tick_ok !== 1'b1) begin n_fail++; $display("FAIL dp_tick got timeout want tick"); end
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
`ifdef AMPM_DP_EN
            want = (c / 4 == 5) ? 1'b0 : 1'b1;
`else
            want = 1'b1;
`endif
            n_run++; if (bus.dp !== want) begin n_fail++; $display("FAIL dp c=%0d anodo=%b got %b want %b", c, bus.anodo, bus.dp, want); end
        end
    endtask

    task automatic test_div1;
        wait_tick(1, tick_ok);
        n_run++; if (tick_ok !== 1'b1) begin n_fail++; $display("FAIL div1_tick got timeout want tick"); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            n_run++; if (bus1.anodo !== exp_an[k]) begin n_fail++; $display("FAIL div1_anodo k=%0d got %b want %b", k, bus1.anodo, exp_an[k]); end
            n_run++; if (bus1.segm !== exp_t[k]) begin n_fail++; $display("FAIL div1_segm k=%0d got %b want %b", k, bus1.segm, exp_t[k]); end
            n_run++; if (bus1.frame_tick !== (k == 5)) begin n_fail++; $display("FAIL div1_tick k=%0d got %b want %b", k, bus1.frame_tick, k == 5); end
        end
    endtask

    initial begin
        test_reset;
        test_time;
        test_date;
        test_update;
        test_blank;
        test_reset_mid;
        test_dp;
        test_div1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
